// File: rtl/bt_pkg.sv
// Shared definitions for the Bluetooth UART receiver: FSM state encoding
// and the clocks-per-bit derivation.
package bt_pkg;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  function automatic int bit_cycles(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/bt_rx_sync.sv
// Two-flop synchronizer for the serial line plus the bit-decision source.
// BT_RX_MAJORITY_EN: rx_vote is the 2-of-3 majority of the last three rx_s values.
module bt_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic rx_vote
);

  logic sync_q;

  // Both stages reset high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_q <= rx;
      rx_s   <= sync_q;
    end
  end

`ifdef BT_RX_MAJORITY_EN
  logic rx_d1;
  logic rx_d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_d1 <= 1'b1;
      rx_d2 <= 1'b1;
    end else begin
      rx_d1 <= rx_s;
      rx_d2 <= rx_d1;
    end
  end

  assign rx_vote = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
`else
  assign rx_vote = rx_s;
`endif

endmodule

// File: rtl/bt_uart_rx.sv
// 8N1 UART receiver for the Bluetooth module line: holds the last good byte,
// pulses rx_valid / frame_err. BT_RX_MAJORITY_EN selects 2-of-3 bit voting.
module bt_uart_rx #(
  parameter int CLK_HZ = 16000000,
  parameter int BAUD   = 9600
) (
  input  logic       WF_CLK,
  input  logic       WF_BUTTON,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  import bt_pkg::*;

  localparam int BIT_CYC = bit_cycles(CLK_HZ, BAUD);
  localparam int HALF    = BIT_CYC / 2;
  localparam int CNT_W   = $clog2(BIT_CYC);
`ifdef BT_RX_MAJORITY_EN
  localparam int START_AT = HALF;
`else
  localparam int START_AT = HALF - 1;
`endif
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(START_AT);
  localparam logic [CNT_W-1:0] CNT_BIT   = CNT_W'(BIT_CYC - 1);

  generate
    if (BIT_CYC < 4) begin : g_bad_rate
      $error("bt_uart_rx: CLK_HZ/BAUD must be at least 4");
    end
  endgenerate

  logic             rx_s;
  logic             rx_vote;
  logic [2:0]       state;
  logic [2:0]       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic             bit_tick;
  logic             stop_ok;
  logic             stop_bad;

  bt_rx_sync u_sync (
    .clk     (WF_CLK),
    .rst_n   (WF_BUTTON),
    .rx      (rx),
    .rx_s    (rx_s),
    .rx_vote (rx_vote)
  );

  always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
    if (!WF_BUTTON) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (!rx_s) state_nx = START;
      START:     if (cnt == CNT_START) state_nx = rx_vote ? IDLE : DATA;
      DATA:      if (cnt == CNT_BIT && idx == 3'd7) state_nx = STOP;
      STOP:      if (cnt == CNT_BIT) state_nx = rx_vote ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    bit_tick = (state == DATA) && (cnt == CNT_BIT);
    stop_ok  = (state == STOP) && (cnt == CNT_BIT) && rx_vote;
    stop_bad = (state == STOP) && (cnt == CNT_BIT) && !rx_vote;
  end

  // cnt restarts on every state change and every data-bit sample, so each
  // sample lands one full bit period after the previous one.
  always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
    if (!WF_BUTTON) begin
      cnt       <= '0;
      idx       <= 3'd0;
      shreg     <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= stop_ok;
      frame_err <= stop_bad;
      if (stop_ok) rx_data <= shreg;
      if (state_nx != state || bit_tick || state == IDLE || state == WAIT_HIGH)
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);
      if (state == START)  idx <= 3'd0;
      else if (bit_tick)   idx <= idx + 3'd1;
      if (bit_tick) shreg <= {rx_vote, shreg[7:1]};
    end
  end

endmodule

// File: tb/tb_bt_uart_rx.sv
// Self-checking bench for bt_uart_rx at CLK_HZ=1600, BAUD=100 (16 clocks/bit).
// Pulses are matched against an expected-event queue built from the frames sent.
module tb_bt_uart_rx;

  localparam int CLK_HZ  = 1600;
  localparam int BAUD    = 100;
  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int HALF    = BIT_CYC / 2;
`ifdef BT_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // Edges from the first edge that sees the start bit to the edge raising the pulse.
  localparam int LAT = 2 + HALF + 9 * BIT_CYC + MAJ;
  localparam int W   = 41;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int         cyc   = 0;
  int         total = 0;
  int         bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;
  logic [7:0] last_good = 8'h00;
  logic       prev_pulse = 1'b0;

  bt_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .WF_CLK    (clk),
    .WF_BUTTON (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // scoreboard: every pulse must match the head of exp_q {err, data, cycle}
  always @(posedge clk) begin
    #1;
    if (rx_valid || frame_err) begin
      total++;
      if (rx_valid && frame_err) begin
        bad++;
        $display("FAIL excl: rx_valid=1 frame_err=1 at cyc=%0d, required at most one", cyc);
      end
      total++;
      if (prev_pulse) begin
        bad++;
        $display("FAIL consec: pulse in consecutive cycles at cyc=%0d, required a gap", cyc);
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected: rx_valid=%0b frame_err=%0b rx_data=%h at cyc=%0d, required no pulse",
                 rx_valid, frame_err, rx_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if (frame_err !== e[40]) begin
          bad++;
          $display("FAIL kind: frame_err=%0b, required %0b", frame_err, e[40]);
        end
        total++;
        if (e[31:0] !== 32'(cyc)) begin
          bad++;
          $display("FAIL timing: pulse at cyc=%0d, required cyc=%0d", cyc, e[31:0]);
        end
        if (!e[40]) begin
          total++;
          if (rx_data !== e[39:32]) begin
            bad++;
            $display("FAIL data: rx_data=%h, required %h", rx_data, e[39:32]);
          end
        end
      end
    end
    prev_pulse = rx_valid || frame_err;
  end

  // driver tasks (all start and end on a falling edge)
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    exp_q.push_back({~stop, (stop ? d : 8'h00), 32'(cyc + LAT + 1)});
    if (stop) last_good = d;
    rx = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    rx = stop;
    repeat (BIT_CYC) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 400) begin
      bad++;
      $display("FAIL %s_timeout: busy=%0b pending=%0d, required idle with nothing pending",
               name, busy, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total += 4;
    if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_data: rx_data=%h, required 00", rx_data); end
    if (rx_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: rx_valid=%b, required 0", rx_valid); end
    if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_ferr: frame_err=%b, required 0", frame_err); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: busy=%b, required 0", busy); end
    rst_n = 1'b1;
    idle(10);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy: busy=%b, required 0", busy); end
  endtask

  task automatic test_single();
    send_frame(8'hA5, 1'b1);
    wait_idle("single");
    total++;
    if (rx_data !== 8'hA5) begin bad++; $display("FAIL single_hold: rx_data=%h, required a5", rx_data); end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h3C, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(2);
    wait_idle("b2b");
    total++;
    if (rx_data !== 8'hFF) begin bad++; $display("FAIL b2b_hold: rx_data=%h, required ff", rx_data); end
  endtask

  task automatic test_random();
    logic [7:0] d;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(d, 1'b1);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 40));
    end
    idle(2);
    wait_idle("random");
    total++;
    if (rx_data !== last_good) begin bad++; $display("FAIL random_hold: rx_data=%h, required %h", rx_data, last_good); end
  endtask

  task automatic test_glitch();
    int busy_cnt = 0;
    idle(5);
    rx = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) rx = 1'b1;
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    total += 3;
    if (busy_cnt !== HALF + MAJ) begin
      bad++; $display("FAIL glitch_busy: busy cycles=%0d, required %0d", busy_cnt, HALF + MAJ);
    end
    if (busy !== 1'b0) begin bad++; $display("FAIL glitch_idle: busy=%b, required 0", busy); end
    if (rx_data !== last_good) begin bad++; $display("FAIL glitch_data: rx_data=%h, required %h", rx_data, last_good); end
  endtask

  task automatic test_frame_err();
    logic [7:0] prior;
    prior = last_good;
    send_frame(8'h55, 1'b0);
    repeat (50) @(negedge clk);
    total += 3;
    if (busy !== 1'b1) begin bad++; $display("FAIL break_busy: busy=%b, required 1", busy); end
    if (rx_data !== prior) begin bad++; $display("FAIL ferr_data: rx_data=%h, required %h", rx_data, prior); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL ferr_seen: pending=%0d, required 0", exp_q.size()); end
    idle(1);
    wait_idle("ferr");
    total++;
    if (rx_data !== prior) begin bad++; $display("FAIL ferr_after: rx_data=%h, required %h", rx_data, prior); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    rx = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    rx = d[4];
    repeat (HALF) @(negedge clk);
    #2;
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    total += 4;
    if (rx_data !== 8'h00) begin bad++; $display("FAIL midrst_data: rx_data=%h, required 00", rx_data); end
    if (rx_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: rx_valid=%b, required 0", rx_valid); end
    if (frame_err !== 1'b0) begin bad++; $display("FAIL midrst_ferr: frame_err=%b, required 0", frame_err); end
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: busy=%b, required 0", busy); end
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    send_frame(8'h81, 1'b1);
    wait_idle("midrst");
    total++;
    if (rx_data !== 8'h81) begin bad++; $display("FAIL midrst_next: rx_data=%h, required 81", rx_data); end
  endtask

`ifdef BT_RX_MAJORITY_EN
  task automatic test_majority();
    logic [9:0] bits;
    bits = {1'b1, 8'h0F, 1'b0};
    idle(5);
    exp_q.push_back({1'b0, 8'h0F, 32'(cyc + LAT + 1)});
    last_good = 8'h0F;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < BIT_CYC; c++) begin
        rx = (c == HALF + 1) ? ~bits[b] : bits[b];
        @(negedge clk);
      end
    end
    idle(2);
    wait_idle("majority");
    total++;
    if (rx_data !== 8'h0F) begin bad++; $display("FAIL maj_data: rx_data=%h, required 0f", rx_data); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_glitch();
    test_frame_err();
    test_reset_mid();
`ifdef BT_RX_MAJORITY_EN
    test_majority();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bt_uart_rx.md
# bt_uart_rx

- Bluetooth-module UART receiver: 8N1, LSB first, idle-high line.
- Recovers bytes from the serial line driven by the Bluetooth module on the robot's IR-sensor header pin.
- Holds the last good byte on a stable bus for the byte-consuming application logic (LED/blink controllers).
- Flags each new byte with a one-cycle strobe; reports framing errors separately.

## Interface
Parameters:
- CLK_HZ, 16000000, system clock frequency in Hz
- BAUD, 9600, line bit rate
- Derived (localparam): BIT_CYC = CLK_HZ/BAUD (integer division, 1666 at defaults); HALF = BIT_CYC/2; BIT_CYC must be ≥ 4 (elaboration error otherwise)

Ports (one clock; reset is asynchronous and active-low):
- WF_CLK  in  1  system clock, all state on rising edge
- WF_BUTTON  in  1  asynchronous active-low reset
- rx  in  1  raw serial line, asynchronous to WF_CLK, idle 1
- rx_data  out  8  last correctly framed byte, held until next good byte
- rx_valid  out  1  one-cycle pulse: rx_data just updated
- frame_err  out  1  one-cycle pulse: stop bit sampled 0
- busy  out  1  high whenever FSM is not in IDLE

## Operation
- rx passes through a 2-flop synchronizer (both flops reset to 1) → rx_s.
- Bit counter cnt width $clog2(BIT_CYC); bit index 0..7; 8-bit shift register, shifts right, new bit enters bit 7.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rx_s==0 → START, cnt=0. Define T0 = that cycle.
  - START: at T0+HALF sample; 0 → DATA, cnt=0, idx=0; 1 → IDLE (glitch rejected, no pulse).
  - DATA: sample every BIT_CYC cycles; bit k sampled at T0+HALF+(k+1)·BIT_CYC; after k=7 → STOP.
  - STOP: sample at T0+HALF+9·BIT_CYC; 1 → load rx_data from shift reg, pulse rx_valid, → IDLE; 0 → pulse frame_err, rx_data unchanged, → WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then → IDLE (line held low/break never produces repeated errors).
- rx_valid and frame_err mutually exclusive, never high two consecutive cycles.
- New start bit accepted in the cycle after STOP returns to IDLE (back-to-back bytes supported, no idle gap required).
- No flow control; consumer must take rx_data any time before the next rx_valid, and may also read it continuously.

## Timing
- Reset values: rx_data=8'h00, rx_valid=0, frame_err=0, busy=0, state=IDLE, synchronizer=1.
- Reset asserted mid-frame: immediate return to reset values; partial byte discarded; rx_data cleared.
- Pin-to-T0 latency: 2–3 cycles (synchronizer + edge detect).
- rx_valid/frame_err registered: high in cycle after stop-bit sample cycle; rx_data changes on same edge rx_valid rises.
- busy rises cycle after T0, falls on the edge entering IDLE.
- Baud error from integer BIT_CYC must stay < 2% over a frame; caller chooses CLK_HZ/BAUD accordingly.

## Configuration
- BT_RX_MAJORITY_EN defined: each sample is the 2-of-3 majority of rx_s at center−1, center, center+1; decision taken at center+1, so every sample instant and rx_valid/frame_err shift one cycle later than listed above.
- Undefined: single sample of rx_s at center cycle, timing exactly as listed.

## Structure
- Shared package bt_pkg: FSM state encoding localparams (IDLE=0, START=1, DATA=2, STOP=3, WAIT_HIGH=4, 3-bit), bit-cycle derivation helper.
- One sub-module: bt_rx_sync — 2-flop synchronizer plus optional majority sampler (BT_RX_MAJORITY_EN), outputs rx_s and voted bit.

## Test plan (CLK_HZ=1600, BAUD=100 → BIT_CYC=16, HALF=8)
- Send 0xA5 with 1 stop bit → exactly one rx_valid pulse ~9.5 bit times after start edge, rx_data=0xA5, frame_err never high.
- Two back-to-back frames 0x3C then 0xFF, no idle gap → two rx_valid pulses 160 cycles apart, rx_data 0x3C then 0xFF.
- 4-cycle low glitch on idle line → no rx_valid/frame_err, busy high ≤ 9 cycles, back to IDLE.
- Frame 0x55 with stop bit 0, line then held low 50 cycles → one frame_err pulse, rx_data keeps prior value, busy stays high until line returns high.
- Assert WF_BUTTON low during bit 4 of a frame → outputs at reset values immediately; next clean frame 0x81 received correctly.
- With BT_RX_MAJORITY_EN: single-cycle inverted spike at each bit center of 0x0F → rx_data=0x0F, rx_valid one cycle later than without macro.
